// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - Shared state type, funct3 codes and special divide results for the M-extension sequencer.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [XLEN-1:0] OVF_QUOT      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OVF_REM       = '0;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - Two-lane conditional two's complement negation.
// Used on the operand side to form magnitudes and on the result side to restore signs.
module muldiv_sign_fix #(
    parameter int width_a = 32,
    parameter int width_b = 32
) (
    input  logic [width_a-1:0] a,
    input  logic               neg_a,
    input  logic [width_b-1:0] b,
    input  logic               neg_b,
    output logic [width_a-1:0] a_fix,
    output logic [width_b-1:0] b_fix
);

    assign a_fix = neg_a ? (~a + 1'b1) : a;
    assign b_fix = neg_b ? (~b + 1'b1) : b;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - Iterative RV32M multiply/divide sequencer for the execute stage.
// One bit per cycle: shift-add multiply or restoring divide, stalling the pipeline while busy.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int data_width = 32,
    parameter int cnt_width  = $clog2(data_width) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MulDivStartE,
    input  logic [2:0]            MulDivOpE,
    input  logic [data_width-1:0] SrcAE,
    input  logic [data_width-1:0] SrcBE,
    input  logic                  FlushE,
    output logic                  MulDivStallE,
    output logic                  MulDivValidE,
    output logic [data_width-1:0] MulDivResultE
);

    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(data_width - 1);

    muldiv_state_t state, state_next;
    logic [cnt_width-1:0]      cnt;
    logic [2*data_width-1:0]   acc, acc_next;
    logic [data_width-1:0]     b_mag, result_q;
    logic [2:0]                op_q;
    logic                      neg_q, neg_r;

    logic                      signed_a, signed_b, sign_a, sign_b;
    logic                      b_zero, sig_ovf, in_special;
    logic [data_width-1:0]     a_mag_in, b_mag_in, special_res, res_sel;
    logic                      accept, finish;

    logic [data_width:0]       mul_sum, rem_shift, rem_diff;
    logic [2*data_width-1:0]   res_lane_a, res_fix_a;
    logic [data_width-1:0]     res_fix_b;

    always_comb begin
        signed_a   = (MulDivOpE == OP_MULH) || (MulDivOpE == OP_MULHSU) ||
                     (MulDivOpE == OP_DIV)  || (MulDivOpE == OP_REM);
        signed_b   = (MulDivOpE == OP_MULH) || (MulDivOpE == OP_DIV) || (MulDivOpE == OP_REM);
        sign_a     = signed_a & SrcAE[data_width-1];
        sign_b     = signed_b & SrcBE[data_width-1];
        b_zero     = (SrcBE == '0);
        sig_ovf    = ((MulDivOpE == OP_DIV) || (MulDivOpE == OP_REM)) &&
                     (SrcAE == data_width'(OVF_QUOT)) && (SrcBE == '1);
        in_special = MulDivOpE[2] && (b_zero || sig_ovf);
        if (b_zero) begin
            special_res = MulDivOpE[1] ? SrcAE : data_width'(DIV_ZERO_QUOT);
        end else begin
            special_res = MulDivOpE[1] ? data_width'(OVF_REM) : data_width'(OVF_QUOT);
        end
    end

    muldiv_sign_fix #(.width_a(data_width), .width_b(data_width)) u_operand_fix (
        .a     (SrcAE),
        .neg_a (sign_a),
        .b     (SrcBE),
        .neg_b (sign_b),
        .a_fix (a_mag_in),
        .b_fix (b_mag_in)
    );

    // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*data_width-1:data_width]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_shift = {acc[2*data_width-1:data_width], acc[data_width-1]};
        rem_diff  = rem_shift - {1'b0, b_mag};
        if (op_q[2]) begin
            acc_next = rem_diff[data_width]
                     ? {rem_shift[data_width-1:0], acc[data_width-2:0], 1'b0}
                     : {rem_diff[data_width-1:0],  acc[data_width-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[data_width-1:1]};
        end
    end

    assign res_lane_a = op_q[2] ? {{data_width{1'b0}}, acc_next[data_width-1:0]} : acc_next;

    muldiv_sign_fix #(.width_a(2*data_width), .width_b(data_width)) u_result_fix (
        .a     (res_lane_a),
        .neg_a (neg_q),
        .b     (acc_next[2*data_width-1:data_width]),
        .neg_b (neg_r),
        .a_fix (res_fix_a),
        .b_fix (res_fix_b)
    );

    always_comb begin
        case (op_q)
            OP_MUL, OP_DIV, OP_DIVU:       res_sel = res_fix_a[data_width-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res_sel = res_fix_a[2*data_width-1:data_width];
            OP_REM, OP_REMU:               res_sel = res_fix_b;
            default:                       res_sel = res_fix_a[data_width-1:0];
        endcase
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (MulDivStartE && !FlushE) begin
                    accept     = 1'b1;
                    state_next = in_special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == last_cnt) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (FlushE) begin
            state_next = IDLE;
            finish     = 1'b0;
        end
        MulDivStallE = ((state == IDLE) && MulDivStartE && !FlushE) || (state == BUSY);
        MulDivValidE = (state == DONE) && !FlushE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            b_mag    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            acc   <= {{data_width{1'b0}}, a_mag_in};
            b_mag <= b_mag_in;
            op_q  <= MulDivOpE;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            if (in_special) begin
                result_q <= special_res;
            end
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            acc <= acc_next;
            if (finish) begin
                result_q <= res_sel;
            end
        end
    end

    assign MulDivResultE = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - Self-checking bench: directed vectors, abort/back-to-back sequences, random ops vs. arithmetic model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op_e;
    logic [31:0] src_a, src_b;
    logic        stall, valid;
    logic [31:0] result;
    logic [31:0] last_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .MulDivStartE  (start),
        .MulDivOpE     (op_e),
        .SrcAE         (src_a),
        .SrcBE         (src_b),
        .FlushE        (flush),
        .MulDivStallE  (stall),
        .MulDivValidE  (valid),
        .MulDivResultE (result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        int          ia, ib;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        za  = {32'd0, a};
        zb  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            3'd0: begin p = za * zb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            3'd7: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op_e = op; src_a = a; src_b = b;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (valid) begin
                seen  = 1'b1;
                start = 1'b0;
                check({name, " result"}, result, exp);
                check({name, " stall_in_done"}, 32'(stall), 32'd0);
            end else begin
                if (stall) stalls++;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check({name, " valid_seen"}, 32'(seen), 32'd1);
        check({name, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " valid_one_cycle"}, 32'(valid), 32'd0);
        last_res = exp;
    endtask

    task automatic abort_at_busy10(input bit use_rst, input logic [31:0] exp_res);
        int    pulses;
        string tag;
        tag    = use_rst ? "rst_abort" : "flush_abort";
        pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; op_e = OP_MUL; src_a = 32'd3; src_b = 32'd4;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        check({tag, " busy_stall"}, 32'(stall), 32'd1);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        check({tag, " stall_dropped"}, 32'(stall), 32'd0);
        check({tag, " result_held"}, result, exp_res);
        for (int k = 0; k < 40; k++) begin
            if (valid) pulses++;
            @(negedge clk);
        end
        check({tag, " no_valid"}, 32'(pulses), 32'd0);
        last_res = exp_res;
    endtask

    task automatic back_to_back();
        int n, t1;
        n  = 0;
        t1 = 0;
        @(posedge clk); #1;
        start = 1'b1; op_e = OP_MUL; src_a = 32'd3; src_b = 32'd4;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (valid) begin
                n++;
                if (n == 1) begin
                    check("b2b first", result, 32'd12);
                    t1    = c;
                    src_a = 32'd5;
                    src_b = 32'd6;
                end else if (n == 2) begin
                    check("b2b second", result, 32'd30);
                    check("b2b spacing", 32'(c - t1), 32'd34);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b pulse_count", 32'(n), 32'd2);
        last_res = 32'd30;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op_e = 3'd0;
        src_a = 32'd0; src_b = 32'd0; last_res = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset valid", 32'(valid), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset result", result, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls);
        end

        abort_at_busy10(1'b0, last_res);
        abort_at_busy10(1'b1, 32'd0);
        back_to_back();

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            bit          sp;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            sp = op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b, ref_model(op, a, b), sp ? 1 : 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the RV32M extension in the execute stage.
- Accepts operands from the execute-stage operand muxes and runs a shift-add multiply or a restoring divide, one bit per cycle.
- Holds the pipeline stalled (fetch, decode and execute) while busy, then presents a one-cycle result to the execute-stage result mux.
- Divide-by-zero and signed overflow complete early with the architecturally defined results.

Parameters:
- data_width, 32, operand/result width.
- cnt_width, $clog2(data_width)+1, iteration counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- MulDivStartE  input  1  execute-stage instruction is an M-extension op; level, held while stalled.
- MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  input  data_width  rs1 value.
- SrcBE  input  data_width  rs2 value.
- FlushE  input  1  hazard-unit flush of the execute stage.
- MulDivStallE  output  1  stall request to the hazard unit.
- MulDivValidE  output  1  result valid this cycle.
- MulDivResultE  output  data_width  result.

Behaviour:
- Single clock, synchronous active-high reset on clk/rst.
- Reset: state IDLE, counter 0, all internal registers 0. MulDivValidE=0, MulDivResultE=0, MulDivStallE=0 (except the combinational term below).
- MulDivStallE is combinational: (state==IDLE & MulDivStartE & ~FlushE) | state==BUSY.
  - It is low in DONE, so the instruction advances in the same cycle the result is valid.
- States:
  - IDLE:
    - MulDivStartE & ~FlushE: latch operands and op.
      - Special case (divide with SrcBE==0, or signed DIV/REM with SrcAE=0x80000000 and SrcBE=0xFFFFFFFF): load the special result and go to DONE.
      - Otherwise convert operands to magnitudes per signedness, record result sign, clear counter and go to BUSY.
  - BUSY:
    - One iteration per cycle; counter increments.
    - Multiply: 2*data_width-bit product register; add the shifted multiplicand when the multiplier LSB is 1, then shift.
    - Divide: restoring; shift remainder left by 1 and subtract the divisor magnitude; if non-negative, keep it and set the quotient bit to 1, else restore.
    - After the data_width-th iteration (counter==data_width-1 at the edge), go to DONE.
  - DONE:
    - MulDivValidE=1 for exactly one cycle; MulDivResultE holds the sign-corrected result.
    - Next state is IDLE unconditionally. A MulDivStartE still high in DONE is ignored, so there is no restart.
- Result selection:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both signed.
  - Quotient sign = signA^signB. Remainder takes the dividend sign. Product sign = signA^signB for the signed operands. All negation is two's complement at full internal width.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (signed and unsigned), remainder = SrcAE.
  - Signed overflow: quotient 0x80000000, remainder 0.
- Latency: normal ops take 34 cycles from acceptance to valid (1 IDLE + 32 BUSY + 1 DONE), i.e. 33 stall cycles. Special cases take 2 cycles (1 stall).
- MulDivResultE holds its value outside DONE; it changes only on entry to DONE.
- FlushE in any state forces IDLE next cycle and suppresses MulDivValidE. FlushE in DONE also drops valid that cycle.
- rst mid-operation: IDLE next cycle, no valid produced.
- Back-to-back M ops: the second is accepted in the IDLE cycle right after DONE.

Decomposition:
- Package muldiv_pkg:
  - State enum (IDLE, BUSY, DONE).
  - funct3 localparams (MUL…REMU).
  - Constants for the special divide results.
- One sub-module, muldiv_sign_fix: combinational magnitude conversion and result sign correction, instantiated twice (operand side, result side).
- The FSM, counter and iteration datapath stay in the top module.

Test Plan:
- MUL 7×(-3): SrcA=7, SrcB=0xFFFFFFFD -> stall 33 cycles, then Valid=1 for one cycle with Result=0xFFFFFFEB; stall low in that cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> Result=0xFFFFFFFE. Same operands with MULH -> 0x00000000. MULHSU -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> Result 0xFFFFFFFF after 1 stall cycle. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same operands -> 0.
- FlushE at BUSY cycle 10 -> IDLE next cycle, stall drops, no Valid. Repeat with rst at BUSY cycle 10 -> same outcome, Result reads 0.
- Two back-to-back MULs (3×4 then 5×6) with Start held -> Valid pulses with 12 then 30, 34 cycles apart, no extra Valid pulse.
